// File: rtl/dpd_adapt_ctrl.sv
// rtl/dpd_adapt_ctrl.sv - dpd_adapt window sequencer with window-mean magnitude qualification
// Produces WAIT -> ADAPT window -> EVAL (-> GAP -> ADAPT ...) and scores each window's mean magnitude.
module dpd_adapt_ctrl #(
    parameter int WAIT_CYC = 1000,
    parameter int LEN_LOG2 = 10,
    parameter int PERIOD   = 0,
    parameter int MAG_TH   = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        start,
    input  logic [19:0] magn,
    output logic        dpd_adapt,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic [19:0] mag_avg,
    output logic [15:0] win_cnt
);

    localparam int WIN_LEN = 1 << LEN_LOG2;
    localparam int MAX_AB  = (WAIT_CYC > WIN_LEN) ? WAIT_CYC : WIN_LEN;
    localparam int CNT_MAX = (MAX_AB > PERIOD) ? MAX_AB : PERIOD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int ACC_W   = 20 + LEN_LOG2;

    // Down-counters are loaded with (length - 1) and the state exits when they reach zero.
    localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] ADAPT_LOAD = CNT_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((PERIOD > 1) ? PERIOD - 2 : 0);
    localparam logic [19:0]      MAG_TH_L   = 20'(MAG_TH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ADAPT,
        S_EVAL,
        S_GAP
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [ACC_W-1:0]   acc;
    logic               enable_d;
    logic               enable_rise;
    logic [19:0]        avg_now;

    assign enable_rise = enable & ~enable_d;
    assign avg_now     = acc[LEN_LOG2 +: 20];
    assign busy        = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            acc       <= '0;
            enable_d  <= 1'b0;
            dpd_adapt <= 1'b0;
            done      <= 1'b0;
            valid     <= 1'b0;
            mag_avg   <= '0;
            win_cnt   <= '0;
        end else begin
            enable_d <= enable;
            done     <= 1'b0;
            // Dropping enable aborts any activity and outranks window completion.
            if ((state != S_IDLE) && !enable) begin
                state     <= S_IDLE;
                dpd_adapt <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (enable_rise) begin
                            if (WAIT_CYC == 0) begin
                                state     <= S_ADAPT;
                                cnt       <= ADAPT_LOAD;
                                acc       <= '0;
                                dpd_adapt <= 1'b1;
                            end else begin
                                state <= S_WAIT;
                                cnt   <= WAIT_LOAD;
                            end
                        end else if (start && enable) begin
                            state     <= S_ADAPT;
                            cnt       <= ADAPT_LOAD;
                            acc       <= '0;
                            dpd_adapt <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (cnt == '0) begin
                            state     <= S_ADAPT;
                            cnt       <= ADAPT_LOAD;
                            acc       <= '0;
                            dpd_adapt <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    S_ADAPT: begin
                        acc <= acc + {{LEN_LOG2{1'b0}}, magn};
                        if (cnt == '0) begin
                            state     <= S_EVAL;
                            dpd_adapt <= 1'b0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    S_EVAL: begin
                        mag_avg <= avg_now;
                        valid   <= (avg_now >= MAG_TH_L);
                        done    <= 1'b1;
                        if ((avg_now >= MAG_TH_L) && (win_cnt != 16'hFFFF)) begin
                            win_cnt <= win_cnt + 16'd1;
                        end
                        if (PERIOD == 0) begin
                            state <= S_IDLE;
                        end else if (PERIOD == 1) begin
                            state     <= S_ADAPT;
                            cnt       <= ADAPT_LOAD;
                            acc       <= '0;
                            dpd_adapt <= 1'b1;
                        end else begin
                            state <= S_GAP;
                            cnt   <= GAP_LOAD;
                        end
                    end
                    S_GAP: begin
                        if (cnt == '0) begin
                            state     <= S_ADAPT;
                            cnt       <= ADAPT_LOAD;
                            acc       <= '0;
                            dpd_adapt <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: begin
                        state     <= S_IDLE;
                        dpd_adapt <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
